// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared state encoding and image framing constants for the boot loader
package boot_loader_pkg;
  typedef enum logic [3:0] {HI0, HI1, INSTR, HD0, HD1, DATA, FLUSH, DONE, ERROR} state_t;
  localparam int HDR_BYTES = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: shifts bytes big-endian into a 32-bit word and pulses word_valid when one completes
module byte_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        word_valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      byte_cnt <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= en && byte_cnt == 2'(WORD_BYTES - 1);
      if (en) begin
        word <= {word[23:0], din};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: parses a length-prefixed host byte image and writes it into instruction/data memory
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        instruction_load,
  output logic        instruction_we,
  output logic [31:0] instruction_addr,
  output logic [31:0] instruction_store,
  output logic        data_load,
  output logic        data_we,
  output logic [31:0] data_addr,
  output logic [7:0]  data_store,
  output logic        boot_done,
  output logic        err
);
  state_t state, state_n;
  logic [7:0] hdr_hi;
  logic [15:0] rem;
  logic [1:0] byte_cnt;
  logic [31:0] cnt_full;
  logic fire, word_last;
  assign fire = in_valid & in_ready;
  assign cnt_full = {16'd0, hdr_hi, in_data};
  assign word_last = byte_cnt == 2'(WORD_BYTES - 1);
  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .en         (fire && state == INSTR),
    .din        (in_data),
    .word       (instruction_store),
    .byte_cnt   (byte_cnt),
    .word_valid (instruction_we)
  );
  always_comb begin
    state_n = state;
    case (state)
      HI0:   if (fire) state_n = HI1;
      HI1:   if (fire) state_n = cnt_full > 32'(IMEM_WORDS) ? ERROR : cnt_full == '0 ? HD0 : INSTR;
      INSTR: if (fire && word_last && rem == 16'd1) state_n = HD0;
      HD0:   if (fire) state_n = HD1;
      HD1:   if (fire) state_n = cnt_full > 32'(DMEM_BYTES) ? ERROR : cnt_full == '0 ? FLUSH : DATA;
      DATA:  if (fire && rem == 16'd1) state_n = FLUSH;
      FLUSH: state_n = DONE;
      default: ;
    endcase
  end
  // rem counts remaining instruction words, then remaining data bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HI0;
      hdr_hi <= '0;
      rem <= '0;
      instruction_addr <= '0;
      data_addr <= '0;
      data_we <= 1'b0;
      data_store <= '0;
    end else begin
      state <= state_n;
      if (fire && (state == HI0 || state == HD0)) hdr_hi <= in_data;
      if (fire && (state == HI1 || state == HD1)) rem <= cnt_full[15:0];
      else if (fire && (state == DATA || (state == INSTR && word_last))) rem <= rem - 16'd1;
      instruction_addr <= instruction_addr + 32'(instruction_we);
      data_addr <= data_addr + 32'(data_we);
      data_we <= fire && state == DATA;
      if (fire && state == DATA) data_store <= in_data;
    end
  end
  assign in_ready = state inside {HI0, HI1, INSTR, HD0, HD1, DATA};
  assign instruction_load = state inside {HI0, HI1, INSTR, HD0, HD1, ERROR};
  assign data_load = state inside {HD0, HD1, DATA, FLUSH, ERROR};
  assign boot_done = state == DONE;
  assign err = state == ERROR;
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized image streaming checked against an image-parsing reference model
module tb_boot_loader;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, instruction_load, instruction_we, data_load, data_we, boot_done, err;
  logic [31:0] instruction_addr, instruction_store, data_addr;
  logic [7:0] data_store;
  int checks = 0, errors = 0, gaps = 0, dbl = 0;
  logic prev_iwe = 1'b0;
  wr_t iq[$], dq[$];
  boot_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .instruction_load(instruction_load), .instruction_we(instruction_we),
    .instruction_addr(instruction_addr), .instruction_store(instruction_store),
    .data_load(data_load), .data_we(data_we), .data_addr(data_addr), .data_store(data_store),
    .boot_done(boot_done), .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (instruction_we) begin
        e.a = instruction_addr;
        e.d = instruction_store;
        iq.push_back(e);
      end
      if (data_we) begin
        e.a = data_addr;
        e.d = {24'd0, data_store};
        dq.push_back(e);
      end
      if (!boot_done && !instruction_load && !data_load) gaps++;
      if (instruction_we && prev_iwe) dbl++;
    end
    prev_iwe = instruction_we && !rst;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_raw(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(posedge clk); #1;
    chk("rst_iload", instruction_load, 1);
    chk("rst_dload", data_load, 0);
    chk("rst_we", {instruction_we, data_we}, 0);
    chk("rst_addr", {instruction_addr, data_addr}, 0);
    chk("rst_store", {instruction_store, data_store}, 0);
    chk("rst_flags", {boot_done, err}, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask
  task automatic mk(input int ni, input int nd, output bq_t q);
    logic [15:0] n;
    logic [31:0] w;
    q = {};
    n = 16'(ni);
    q.push_back(n[15:8]);
    q.push_back(n[7:0]);
    for (int i = 0; i < ni; i++) begin
      w = $urandom;
      for (int k = 3; k >= 0; k--) q.push_back(w[8*k +: 8]);
    end
    n = 16'(nd);
    q.push_back(n[15:8]);
    q.push_back(n[7:0]);
    for (int i = 0; i < nd; i++) q.push_back(8'($urandom));
  endtask
  // mode 0: full rate, 1: one idle cycle before every byte, 2: random idle bursts
  task automatic run_bytes(input bq_t img, input int mode);
    int ni, nd, ib, db, g, wbase, dbase;
    logic iw, dw;
    ib = iq.size();
    db = dq.size();
    ni = int'({img[0], img[1]});
    wbase = 2;
    dbase = 4 + 4 * ni;
    nd = int'({img[dbase - 2], img[dbase - 1]});
    for (int p = 0; p < img.size(); p++) begin
      g = mode == 1 ? 1 : mode == 2 ? ($urandom_range(3) == 0 ? int'($urandom_range(3, 1)) : 0) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      chk("ready", in_ready, 1);
      push_raw(img[p]);
      iw = p >= wbase && p < dbase - 2 && (p - wbase) % 4 == 3;
      dw = p >= dbase;
      chk("iwe", instruction_we, iw);
      if (iw) begin
        chk("istore", instruction_store, {img[p-3], img[p-2], img[p-1], img[p]});
        chk("iaddr", instruction_addr, (p - wbase) / 4);
      end
      chk("dwe", data_we, dw);
      if (dw) begin
        chk("dstore", data_store, img[p]);
        chk("daddr", data_addr, p - dbase);
      end
      chk("iload_held", instruction_load | data_load, 1);
    end
    chk("done_early", boot_done, 0);
    @(posedge clk); #1;
    chk("done", boot_done, 1);
    chk("released", {instruction_load, data_load, in_ready}, 0);
    chk("no_err", err, 0);
    chk("i_count", iq.size() - ib, ni);
    chk("d_count", dq.size() - db, nd);
    for (int i = 0; i < ni && ib + i < iq.size(); i++) begin
      chk("i_wr_addr", iq[ib+i].a, i);
      chk("i_wr_data", iq[ib+i].d, {img[wbase+4*i], img[wbase+4*i+1], img[wbase+4*i+2], img[wbase+4*i+3]});
    end
    for (int i = 0; i < nd && db + i < dq.size(); i++) begin
      chk("d_wr_addr", dq[db+i].a, i);
      chk("d_wr_data", dq[db+i].d, img[dbase+i]);
    end
    repeat (3) @(posedge clk);
    #1 chk("done_sticky", boot_done, 1);
  endtask
  task automatic run_err(input bq_t hdr);
    int ib, db;
    ib = iq.size();
    db = dq.size();
    foreach (hdr[i]) begin
      chk("err_ready", in_ready, 1);
      push_raw(hdr[i]);
    end
    chk("err", err, 1);
    chk("err_ready_low", in_ready, 0);
    chk("err_loads", {instruction_load, data_load}, 2'b11);
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("err_hold", {err, boot_done, in_ready}, 3'b100);
    chk("err_no_strobe", (iq.size() - ib) + (dq.size() - db), 0);
  endtask
  initial begin
    bq_t img;
    do_reset();
    run_bytes('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h01, 8'hAB}, 0);
    do_reset();
    mk(3, 2, img);
    run_bytes(img, 1);
    do_reset();
    run_bytes('{8'h00, 8'h00, 8'h00, 8'h00}, 0);
    do_reset();
    run_err('{8'h01, 8'h01});
    do_reset();
    run_err('{8'h00, 8'h00, 8'h04, 8'h01});
    do_reset();
    mk(2, 3, img);
    for (int p = 0; p < 8; p++) push_raw(img[p]);
    do_reset();
    run_bytes(img, 2);
    for (int t = 0; t < 4; t++) begin
      do_reset();
      mk(int'($urandom_range(8, 1)), int'($urandom_range(20, 0)), img);
      run_bytes(img, 2);
    end
    do_reset();
    mk(256, 1024, img);
    run_bytes(img, 0);
    chk("flag_gap", gaps, 0);
    chk("istrobe_width", dbl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
